// File: rtl/stack_row_slider.sv
// ============================================================================
// Module   : stack_row_slider
// Purpose  : Sweeps a bar of lit cells across a row and judges the drop
//            against the row below.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_row_slider #(
  parameter int COLS       = 16,
  parameter int BASE_TICKS = 500000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [3:0]      speed,
  input  logic [3:0]      num_blocks,
  input  logic            drop,
  input  logic [COLS-1:0] prev_row,
  output logic [COLS-1:0] row_out,
  output logic            row_valid,
  output logic [COLS-1:0] result_row,
  output logic            next_signal,
  output logic            fail
);

  localparam int PW = $clog2(COLS) + 1;
  localparam int CW = $clog2(BASE_TICKS * 15 + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, JUDGE = 2'd2} state_t;

  state_t        state, state_next;
  logic [PW-1:0] pos, pos_next, w, w_in;
  logic          dir_left, dir_next;
  logic [CW-1:0] count;
  logic [3:0]    speed_eff, speed_in_eff;
  logic          step;
  logic [COLS-1:0] overlap;

  function automatic logic [COLS-1:0] bar_mask(input logic [PW-1:0] width,
                                               input logic [PW-1:0] p);
    logic [COLS:0] one;
    logic [COLS:0] m;
    one = {{COLS{1'b0}}, 1'b1};
    m   = (one << width) - one;
    return m[COLS-1:0] << p;
  endfunction

  function automatic logic [CW-1:0] period_m1(input logic [3:0] s);
    return CW'(BASE_TICKS * (16 - int'(s)) - 1);
  endfunction

  always_comb begin
    state_next   = state;
    pos_next     = pos;
    dir_next     = dir_left;
    speed_in_eff = (speed == 4'd0) ? 4'd1 : speed;
    if (num_blocks == 4'd0)
      w_in = PW'(1);
    else if (int'(num_blocks) > COLS)
      w_in = PW'(COLS);
    else
      w_in = PW'(num_blocks);
    step    = (state == MOVE) && (count == '0);
    overlap = row_out & prev_row;

    // Full-width bar never moves; otherwise bounce turns and moves in one step.
    if (w != PW'(COLS)) begin
      if (!dir_left) begin
        if (pos + w == PW'(COLS)) begin
          dir_next = 1'b1;
          pos_next = pos - PW'(1);
        end else begin
          pos_next = pos + PW'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_next = 1'b0;
          pos_next = pos + PW'(1);
        end else begin
          pos_next = pos - PW'(1);
        end
      end
    end

    case (state)
      IDLE:    if (start) state_next = MOVE;
      MOVE:    if (drop) state_next = JUDGE;
      JUDGE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pos         <= '0;
      w           <= '0;
      dir_left    <= 1'b0;
      count       <= '0;
      speed_eff   <= '0;
      row_out     <= '0;
      row_valid   <= 1'b0;
      result_row  <= '0;
      next_signal <= 1'b0;
      fail        <= 1'b0;
    end else begin
      next_signal <= 1'b0;
      fail        <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            speed_eff  <= speed_in_eff;
            w          <= w_in;
            pos        <= '0;
            dir_left   <= 1'b0;
            count      <= period_m1(speed_in_eff);
            row_out    <= bar_mask(w_in, '0);
            row_valid  <= 1'b1;
            result_row <= '0;
          end
        end
        MOVE: begin
          // A drop wins over a coincident step so the judged mask is the visible one.
          if (drop) begin
            result_row  <= overlap;
            next_signal <= |overlap;
            fail        <= ~|overlap;
          end else if (step) begin
            pos      <= pos_next;
            dir_left <= dir_next;
            count    <= period_m1(speed_eff);
            row_out  <= bar_mask(w, pos_next);
          end else begin
            count <= count - CW'(1);
          end
        end
        JUDGE: begin
          row_out   <= '0;
          row_valid <= 1'b0;
        end
        default: begin
          row_out   <= '0;
          row_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
